mac_unit: RTL and testbench

- Pipelined unsigned multiply-accumulate unit: each clock it captures one operand pair, multiplies them, and adds the product into a running accumulator.
- Used as a datapath leaf, for example in a filter or dot-product engine.
- No handshake: every cycle's operand pair is accumulated. A pair of zeros leaves the sum unchanged.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_mult.sv | 52 +++++
 rtl/mac_unit.sv | 74 +++++++
 tb/tb_mac_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg
// Shared constants and types for the multiply-accumulate unit and its bench.
//   DATA_WIDTH_DEF : default operand width
//   acc_width()    : accumulator/product width for a given operand width
//   PROD_WIDTH     : product/accumulator width at the default operand width
//   prod_t         : product/accumulator type at the default operand width
package mac_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;

    function automatic int unsigned acc_width(input int unsigned w);
        return 2 * w;
    endfunction

    localparam int unsigned PROD_WIDTH = acc_width(DATA_WIDTH_DEF);

    typedef logic [PROD_WIDTH-1:0] prod_t;

endpackage

// File: rtl/mac_mult.sv
// mac_mult
// Two-stage registered unsigned multiplier: operand registers followed by a
// full-width product register.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears operand and product registers
//   en     : operand capture enable; operand registers hold when low
//   op_a   : unsigned operand A
//   op_b   : unsigned operand B
//   prod   : registered product a_q * b_q, 2*DATA_WIDTH bits
module mac_mult
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [DATA_WIDTH-1:0]            op_a,
    input  logic [DATA_WIDTH-1:0]            op_b,
    output logic [acc_width(DATA_WIDTH)-1:0] prod
);

    localparam int unsigned PW = acc_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]         p_q, p_d;

    always_comb begin
        a_d = en ? op_a : a_q;
        b_d = en ? op_b : b_q;
        // Zero-extend both operands so the multiply is evaluated at full
        // product width; a W x W product always fits in 2W bits.
        p_d = {{DATA_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, b_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    assign prod = p_q;

endmodule

// File: rtl/mac_unit.sv
// mac_unit
// Pipelined unsigned multiply-accumulate. Every cycle one operand pair is
// captured, multiplied, and the product added (modulo 2^(2*DATA_WIDTH)) into
// a running accumulator. A pair presented before edge N shows in result after
// edge N+2. There is no clear port; reset is the only way to zero the sum.
// Ports:
//   clk      : rising-edge clock
//   a_reset  : asynchronous active-low reset; assertion clears all state at
//              once, release is synchronised to clk before capture resumes
//   op_a     : unsigned operand A, sampled every rising edge
//   op_b     : unsigned operand B, sampled every rising edge
//   result   : accumulator register, 2*DATA_WIDTH bits
module mac_unit
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             a_reset,
    input  logic [DATA_WIDTH-1:0]            op_a,
    input  logic [DATA_WIDTH-1:0]            op_b,
    output logic [acc_width(DATA_WIDTH)-1:0] result
);

    localparam int unsigned AW = acc_width(DATA_WIDTH);

    // Reset-release synchroniser: shifts in ones after a_reset goes high.
    // The second flop is the run enable that lets the operand registers load.
    logic [1:0]    sync_q, sync_d;
    logic          run_en;
    logic [AW-1:0] prod;
    logic [AW-1:0] acc_q, acc_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign run_en = sync_q[1];

    mac_mult #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mult (
        .clk  (clk),
        .rst_n(a_reset),
        .en   (run_en),
        .op_a (op_a),
        .op_b (op_b),
        .prod (prod)
    );

    // Carry-out of the add is dropped: the accumulator wraps silently.
    always_comb begin
        acc_d = acc_q + prod;
    end

    always_ff @(posedge clk or negedge a_reset) begin
        if (!a_reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result = acc_q;

endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit
// Directed bench for mac_unit at DATA_WIDTH=8. Inputs are driven 1 ns after
// each rising edge and result is checked at that same point, so a value
// checked right after the edge that captured pair N reflects pairs up to N-2.
module tb_mac_unit;
    import mac_pkg::*;

    localparam int unsigned DW = DATA_WIDTH_DEF;

    logic          clk;
    logic          a_reset;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    prod_t         result;

    int unsigned   checks;
    int unsigned   errors;
    prod_t         exp_q[$];

    mac_unit #(
        .DATA_WIDTH(DW)
    ) dut (
        .clk    (clk),
        .a_reset(a_reset),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result)
    );

    // Clock / reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input prod_t got, input prod_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: result=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // Present a pair, let one rising edge capture it, return 1 ns later.
    task automatic tick(input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_a = a;
        op_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input prod_t exp);
        tick(a, b);
        check(tag, result, exp);
    endtask

    // Hold reset with random operands over several edges, release mid-cycle,
    // then idle with zero operands until the release has propagated.
    task automatic do_reset(input string tag);
        a_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
            check({tag, "_held"}, result, '0);
        end
        #2;
        a_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick('0, '0);
        end
        check({tag, "_settled"}, result, '0);
    endtask

    initial begin
        logic [DW-1:0] va[6];
        logic [DW-1:0] vb[6];
        prod_t         ve[6];
        prod_t         exp;

        checks  = 0;
        errors  = 0;
        a_reset = 1'b0;
        op_a    = '0;
        op_b    = '0;

        // Asynchronous clear before any clock edge.
        #1;
        check("reset_no_edge", result, '0);

        // Basic accumulate: 0x186, +0xBE -> 0x244, +0x33 -> 0x277.
        do_reset("rst1");
        va = '{8'h0F, 8'h26, 8'h03, 8'h00, 8'h00, 8'h00};
        vb = '{8'h1A, 8'h05, 8'h11, 8'h00, 8'h00, 8'h00};
        ve = '{16'h0000, 16'h0000, 16'h0186, 16'h0244, 16'h0277, 16'h0277};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ve[i]);
        end
        for (int i = 0; i < 6; i++) begin
            tick(va[i], vb[i]);
            exp = exp_q.pop_front();
            check($sformatf("basic_%0d", i), result, exp);
        end

        // Latency: single pair then zeros; 6 appears two edges later.
        do_reset("rst2");
        tick_chk("lat_n",   8'h02, 8'h03, 16'h0000);
        tick_chk("lat_n1",  8'h00, 8'h00, 16'h0000);
        tick_chk("lat_n2",  8'h00, 8'h00, 16'h0006);
        tick_chk("lat_n3",  8'h00, 8'h00, 16'h0006);

        // Wraparound: 0xFE01 + 0xFE01 -> 0xFC02, + 0x00FE -> 0xFD00.
        do_reset("rst3");
        tick_chk("wrap_0",  8'hFF, 8'hFF, 16'h0000);
        tick_chk("wrap_1",  8'hFF, 8'hFF, 16'h0000);
        tick_chk("wrap_2",  8'h01, 8'hFE, 16'hFE01);
        tick_chk("wrap_3",  8'h00, 8'h00, 16'hFC02);
        tick_chk("wrap_4",  8'h00, 8'h00, 16'hFD00);
        tick_chk("wrap_5",  8'h00, 8'h00, 16'hFD00);

        // Boundary operands: zero in either lane adds nothing, 1*1 adds 1.
        tick_chk("bnd_0",   8'h00, 8'hFF, 16'hFD00);
        tick_chk("bnd_1",   8'hFF, 8'h00, 16'hFD00);
        tick_chk("bnd_2",   8'h01, 8'h01, 16'hFD00);
        tick_chk("bnd_3",   8'h00, 8'h00, 16'hFD00);
        tick_chk("bnd_4",   8'h00, 8'h00, 16'hFD01);
        tick_chk("bnd_5",   8'h00, 8'h00, 16'hFD01);

        // Exact wrap to zero: 0xFD01 + 0x2FA = 0xFFFB, + 4 = 0xFFFF, + 1 = 0.
        tick_chk("top_0",   8'hFE, 8'h03, 16'hFD01);
        tick_chk("top_1",   8'h02, 8'h02, 16'hFD01);
        tick_chk("top_2",   8'h01, 8'h01, 16'hFFFB);
        tick_chk("top_3",   8'h00, 8'h00, 16'hFFFF);
        tick_chk("top_4",   8'h00, 8'h00, 16'h0000);
        tick_chk("top_5",   8'h00, 8'h00, 16'h0000);

        // Mid-stream reset with 0x10*0x10 = 0x100 per cycle in flight.
        do_reset("rst4");
        tick_chk("strm_0",  8'h10, 8'h10, 16'h0000);
        tick_chk("strm_1",  8'h10, 8'h10, 16'h0000);
        tick_chk("strm_2",  8'h10, 8'h10, 16'h0100);
        tick_chk("strm_3",  8'h10, 8'h10, 16'h0200);
        #2;
        a_reset = 1'b0;
        #1;
        check("midrst_async", result, '0);
        #2;
        a_reset = 1'b1;
        op_a    = '0;
        op_b    = '0;
        // Any product left in the operand or product stage would show here.
        for (int i = 0; i < 4; i++) begin
            tick_chk($sformatf("midrst_flush_%0d", i), 8'h00, 8'h00, 16'h0000);
        end
        tick_chk("restart_0", 8'h10, 8'h10, 16'h0000);
        tick_chk("restart_1", 8'h00, 8'h00, 16'h0000);
        tick_chk("restart_2", 8'h00, 8'h00, 16'h0100);
        tick_chk("restart_3", 8'h00, 8'h00, 16'h0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
